// File: rtl/tlp_tx_packer_if.sv
// 64-bit AXI4-Stream transmit bundle toward the PCIe slot.
// master drives the beat, slave returns tready.
interface tlp_tx_packer_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic [3:0]  tuser;

  modport master (
    output tdata, tkeep, tlast, tvalid, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid, tuser,
    output tready
  );
endinterface

// File: rtl/tlp_tx_packer.sv
// Packs a 32-bit TLP DW stream into 64-bit AXIS beats,
// checks DW count against the header and counts sent TLPs.
module tlp_tx_packer (
  input  logic        user_clk,
  input  logic        user_reset,
  input  logic [31:0] dw_data,
  input  logic        dw_valid,
  input  logic        dw_last,
  output logic        dw_ready,
  tlp_tx_packer_if.master tx,
  output logic        tlp_sent,
  output logic [15:0] tlp_count,
  output logic        len_err
);

  logic [31:0] acc;
  logic        acc_full;
  logic [10:0] dw_cnt;
  logic [2:0]  fmt_q;
  logic [9:0]  len_q;

  logic        dw_fire;
  logic        beat_fire;
  logic        load;
  logic        first;
  logic [2:0]  cur_fmt;
  logic [9:0]  cur_len;
  logic [10:0] hdr;
  logic [10:0] payload;
  logic [10:0] expected;
  logic [11:0] cnt_next;

  assign dw_ready  = !tx.tvalid || tx.tready;
  assign dw_fire   = dw_valid && dw_ready;
  assign beat_fire = tx.tvalid && tx.tready;
  assign load      = dw_fire && (acc_full || dw_last);
  assign tx.tuser  = 4'b0000;

  // header fields come straight off the bus on DW0
  always_comb begin
    first    = (dw_cnt == 11'd0);
    cur_fmt  = first ? dw_data[31:29] : fmt_q;
    cur_len  = first ? dw_data[9:0] : len_q;
    hdr      = cur_fmt[0] ? 11'd4 : 11'd3;
    payload  = 11'd0;
    if (cur_fmt[1])
      payload = (cur_len == 10'd0) ? 11'd1024
                                   : {1'b0, cur_len};
    expected = hdr + payload;
    cnt_next = {1'b0, dw_cnt} + 12'd1;
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      tx.tdata  <= 64'h0;
      tx.tkeep  <= 8'h00;
      tx.tlast  <= 1'b0;
      tx.tvalid <= 1'b0;
      acc       <= 32'h0;
      acc_full  <= 1'b0;
      dw_cnt    <= 11'd0;
      fmt_q     <= 3'd0;
      len_q     <= 10'd0;
      tlp_sent  <= 1'b0;
      tlp_count <= 16'd0;
      len_err   <= 1'b0;
    end else begin
      tlp_sent <= beat_fire && tx.tlast;
      if (beat_fire && tx.tlast)
        tlp_count <= tlp_count + 16'd1;

      if (load) begin
        tx.tvalid <= 1'b1;
        if (acc_full) begin
          tx.tdata <= {dw_data, acc};
          tx.tkeep <= 8'hFF;
          tx.tlast <= dw_last;
        end else begin
          tx.tdata <= {32'h0, dw_data};
          tx.tkeep <= 8'h0F;
          tx.tlast <= 1'b1;
        end
      end else if (beat_fire) begin
        tx.tvalid <= 1'b0;
      end

      if (dw_fire) begin
        if (!acc_full && !dw_last) begin
          acc      <= dw_data;
          acc_full <= 1'b1;
        end else begin
          acc_full <= 1'b0;
        end
      end

      len_err <= 1'b0;
      if (dw_fire) begin
        if (first) begin
          fmt_q <= dw_data[31:29];
          len_q <= dw_data[9:0];
        end
        if (dw_last) begin
          len_err <= (cnt_next != {1'b0, expected});
          dw_cnt  <= 11'd0;
        end else if (dw_cnt != 11'd2047) begin
          dw_cnt  <= cnt_next[10:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_tlp_tx_packer.sv
// Directed bench for tlp_tx_packer: beat packing, backpressure,
// length errors, mid-TLP reset and tlp_count wrap.
module tb_tlp_tx_packer;

  logic        user_clk;
  logic        user_reset;
  logic [31:0] dw_data;
  logic        dw_valid;
  logic        dw_last;
  logic        dw_ready;
  logic        tlp_sent;
  logic [15:0] tlp_count;
  logic        len_err;

  tlp_tx_packer_if txi ();

  tlp_tx_packer dut (
    .user_clk   (user_clk),
    .user_reset (user_reset),
    .dw_data    (dw_data),
    .dw_valid   (dw_valid),
    .dw_last    (dw_last),
    .dw_ready   (dw_ready),
    .tx         (txi),
    .tlp_sent   (tlp_sent),
    .tlp_count  (tlp_count),
    .len_err    (len_err)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int n_chk = 0;
  int n_pass = 0;
  int stalls = 0;
  int sent_cnt = 0;
  int err_cnt = 0;
  logic [72:0] q[$];

  always @(negedge user_clk) begin
    if (txi.tvalid && txi.tready)
      q.push_back({txi.tkeep, txi.tlast, txi.tdata});
    if (tlp_sent) sent_cnt++;
    if (len_err) err_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    dw_data  = d;
    dw_last  = l;
    dw_valid = 1'b1;
    @(negedge user_clk);
    while (!dw_ready && n < 100) begin
      n++;
      stalls++;
      @(negedge user_clk);
    end
    if (!dw_ready) chk("send_timeout", dw_ready, 1);
    @(posedge user_clk);
    #1;
    dw_valid = 1'b0;
    dw_last  = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge user_clk);
    #1;
  endtask

  task automatic exp_beat(input string tag,
                          input logic [7:0] k,
                          input logic t,
                          input logic [63:0] d);
    logic [72:0] b;
    if (q.size() == 0) begin
      chk(tag, q.size(), 1);
    end else begin
      b = q.pop_front();
      chk(tag, b, {k, t, d});
    end
  endtask

  task automatic do_reset();
    user_reset = 1'b1;
    repeat (2) @(posedge user_clk);
    #1;
    user_reset = 1'b0;
  endtask

  int s0, e0, st0, n;

  initial begin
    user_reset = 1'b1;
    dw_data    = 32'h0;
    dw_valid   = 1'b0;
    dw_last    = 1'b0;
    txi.tready = 1'b1;
    repeat (3) @(posedge user_clk);
    #1;
    user_reset = 1'b0;
    chk("rst_tvalid", txi.tvalid, 0);
    chk("rst_tkeep", txi.tkeep, 8'h00);
    chk("rst_tlast", txi.tlast, 0);
    chk("rst_tdata", txi.tdata, 64'h0);
    chk("rst_tuser", txi.tuser, 4'h0);
    chk("rst_sent", tlp_sent, 0);
    chk("rst_err", len_err, 0);
    chk("rst_cnt", tlp_count, 0);
    chk("rst_ready", dw_ready, 1);

    // 3DW MRd
    s0 = sent_cnt; e0 = err_cnt;
    send(32'h00000001, 0);
    send(32'h11111111, 0);
    send(32'h22222222, 1);
    drain();
    exp_beat("mrd_b0", 8'hFF, 0, 64'h11111111_00000001);
    exp_beat("mrd_b1", 8'h0F, 1, 64'h00000000_22222222);
    chk("mrd_q", q.size(), 0);
    chk("mrd_sent", sent_cnt - s0, 1);
    chk("mrd_cnt", tlp_count, 1);
    chk("mrd_err", err_cnt - e0, 0);

    // completion with data, full rate
    s0 = sent_cnt; e0 = err_cnt; st0 = stalls;
    send(32'h4A000001, 0);
    send(32'hA1A1A1A1, 0);
    send(32'hA2A2A2A2, 0);
    send(32'hA3A3A3A3, 1);
    drain();
    chk("cpl_stall", stalls - st0, 0);
    exp_beat("cpl_b0", 8'hFF, 0, 64'hA1A1A1A1_4A000001);
    exp_beat("cpl_b1", 8'hFF, 1, 64'hA3A3A3A3_A2A2A2A2);
    chk("cpl_q", q.size(), 0);
    chk("cpl_sent", sent_cnt - s0, 1);
    chk("cpl_cnt", tlp_count, 2);
    chk("cpl_err", err_cnt - e0, 0);

    // same completion under backpressure
    s0 = sent_cnt; e0 = err_cnt;
    txi.tready = 1'b0;
    fork
      begin
        send(32'h4A000001, 0);
        send(32'hB1B1B1B1, 0);
        send(32'hB2B2B2B2, 0);
        send(32'hB3B3B3B3, 1);
      end
      begin
        n = 0;
        while (!txi.tvalid && n < 20) begin
          @(posedge user_clk);
          #1;
          n++;
        end
        chk("bp_tvalid", txi.tvalid, 1);
        repeat (5) begin
          @(negedge user_clk);
          chk("bp_data", txi.tdata,
              64'hB1B1B1B1_4A000001);
          chk("bp_valid", txi.tvalid, 1);
          chk("bp_ready", dw_ready, 0);
        end
        @(posedge user_clk);
        #1;
        txi.tready = 1'b1;
      end
    join
    drain();
    exp_beat("bp_b0", 8'hFF, 0, 64'hB1B1B1B1_4A000001);
    exp_beat("bp_b1", 8'hFF, 1, 64'hB3B3B3B3_B2B2B2B2);
    chk("bp_q", q.size(), 0);
    chk("bp_cnt", tlp_count, 3);
    chk("bp_err", err_cnt - e0, 0);

    // MWr32 len=2 but 4 DWs: length error
    s0 = sent_cnt; e0 = err_cnt;
    send(32'h40000002, 0);
    send(32'hC1C1C1C1, 0);
    send(32'hC2C2C2C2, 0);
    send(32'hC3C3C3C3, 1);
    drain();
    exp_beat("mwr_b0", 8'hFF, 0, 64'hC1C1C1C1_40000002);
    exp_beat("mwr_b1", 8'hFF, 1, 64'hC3C3C3C3_C2C2C2C2);
    chk("mwr_q", q.size(), 0);
    chk("mwr_err", err_cnt - e0, 1);
    chk("mwr_cnt", tlp_count, 4);

    // reset after 3 DWs of a 6-DW TLP
    send(32'h40000003, 0);
    send(32'hD1D1D1D1, 0);
    send(32'hD2D2D2D2, 0);
    user_reset = 1'b1;
    @(posedge user_clk);
    #1;
    chk("mid_tvalid", txi.tvalid, 0);
    chk("mid_cnt", tlp_count, 0);
    user_reset = 1'b0;
    q.delete();
    s0 = sent_cnt; e0 = err_cnt;
    chk("mid_ready", dw_ready, 1);
    send(32'h4A000001, 0);
    send(32'hE1E1E1E1, 0);
    send(32'hE2E2E2E2, 0);
    send(32'hE3E3E3E3, 1);
    drain();
    exp_beat("mid_b0", 8'hFF, 0, 64'hE1E1E1E1_4A000001);
    exp_beat("mid_b1", 8'hFF, 1, 64'hE3E3E3E3_E2E2E2E2);
    chk("mid_q", q.size(), 0);
    chk("mid_sent", sent_cnt - s0, 1);
    chk("mid_cnt1", tlp_count, 1);
    chk("mid_err", err_cnt - e0, 0);

    // single-DW TLPs back to back: len_err each, count wrap
    do_reset();
    s0 = sent_cnt; e0 = err_cnt; st0 = stalls;
    for (int i = 0; i < 65535; i++)
      send(i[31:0], 1);
    drain();
    chk("wrap_ffff", tlp_count, 16'hFFFF);
    send(32'h0000FFFF, 1);
    drain();
    chk("wrap_zero", tlp_count, 0);
    chk("wrap_sent", sent_cnt - s0, 65536);
    chk("wrap_err", err_cnt - e0, 65536);
    chk("wrap_stall", stalls - st0, 0);
    q.delete();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
